keyboard_fifo: RTL

Clocked, buffered successor to the combinational key encoder. It samples an NKEYS-wide one-hot/multi-hot key vector and priority-encodes it. It debounces presses and releases, and optionally generates typematic repeats. Key codes are queued in a first-word-fall-through FIFO, which the CPU/IO bus drains through a valid/ready handshake.

---
 rtl/keyboard_fifo.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/keyboard_fifo.sv
// keyboard_fifo: synchronises a multi-hot key vector, priority-encodes it
// (highest index wins), debounces presses and releases, optionally generates
// typematic repeats, and queues the resulting codes in a first-word
// fall-through FIFO.
//
// Handshake: char/char_valid are registered and describe the FIFO head.
// A transfer (pop) happens on a rising edge where char_valid & char_ready are
// both 1; char_ready is ignored while char_valid is 0. char_valid never drops
// without a pop or a reset.
module keyboard_fifo #(
  parameter int NKEYS        = 256,
  parameter int CODE_W       = 8,
  parameter int DEBOUNCE     = 4,
  parameter int DEPTH        = 8,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NKEYS-1:0]         keys,
  output logic [CODE_W-1:0]        char,
  output logic                     char_valid,
  input  logic                     char_ready,
  output logic                     PAK,
  output logic                     key_down,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_e;

  localparam int MAXC = (DEBOUNCE > REPEAT_DELAY)
                        ? ((DEBOUNCE > REPEAT_RATE) ? DEBOUNCE : REPEAT_RATE)
                        : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam int CW = $clog2(MAXC + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DB_C    = CW'(DEBOUNCE);
  localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);

  logic [NKEYS-1:0]  s1_q, ks_q;
  logic [CODE_W-1:0] cur;
  logic              any;
  logic              pak_q;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic              rep_q, rep_d;   // first repeat of this hold already issued
  logic              push;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       count_q, count_d;
  logic [CODE_W-1:0] char_q, char_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              pop, full, wr_en, drop;

  // Two-flop synchroniser; left out of reset so a key held across reset is
  // seen again immediately and only has to re-debounce.
  always_ff @(posedge clk) begin
    s1_q <= keys;
    ks_q <= s1_q;
  end

  // Highest set bit of the synchronised vector wins.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (ks_q[i]) cur = CODE_W'(i);
    end
  end

  assign any = |ks_q;

  // Press-any-key flag, registered in parallel with the second sync stage.
  always_ff @(posedge clk) begin
    if (rst) pak_q <= 1'b0;
    else     pak_q <= |s1_q;
  end

  // Debounce/repeat state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      rep_q   <= rep_d;
    end
  end

  // Next-state logic: one shared counter times debounce and repeat intervals.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    rep_d   = rep_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = PRESS_DB;
          cand_d  = cur;
          cnt_d   = ONE_C;
        end
      end
      PRESS_DB: begin
        if (!any) begin
          state_d = IDLE;
        end else if (cur != cand_q) begin
          cand_d = cur;
          cnt_d  = ONE_C;
        end else if (cnt_q == DB_C) begin
          push    = 1'b1;
          state_d = HELD;
          cnt_d   = ONE_C;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      HELD: begin
        if (!any) begin
          state_d = REL_DB;
          cnt_d   = ONE_C;
        end else if (cur != cand_q) begin
          state_d = PRESS_DB;
          cand_d  = cur;
          cnt_d   = ONE_C;
        end else if (REPEAT_EN != 0) begin
          if (cnt_q == (rep_q ? RATE_C : DELAY_C)) begin
            push  = 1'b1;
            cnt_d = ONE_C;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end
      REL_DB: begin
        if (any) begin
          if (cur == cand_q) begin
            state_d = HELD;
            cnt_d   = ONE_C;
            rep_d   = 1'b0;
          end else begin
            state_d = PRESS_DB;
            cand_d  = cur;
            cnt_d   = ONE_C;
          end
        end else if (cnt_q == DB_C) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves in
  // the same cycle; otherwise the event is dropped.
  always_comb begin
    pop     = valid_q & char_ready;
    full    = (count_q == FULL_C);
    wr_en   = push & (~full | pop);
    drop    = push & full & ~pop;
    wr_d    = wr_q + AW'(wr_en);
    rd_d    = rd_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    valid_d = (count_d != '0);
    if (count_d == '0) begin
      char_d = '0;
    end else if (wr_en && ((count_q - (AW+1)'(pop)) == '0)) begin
      char_d = cand_q;      // the entry being written becomes the head
    end else begin
      char_d = mem_q[rd_d];
    end
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // Storage array; contents are don't-care while not covered by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= cand_q;
  end

  // FIFO pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign char        = char_q;
  assign char_valid  = valid_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign PAK         = pak_q;
  assign key_down    = (state_q == HELD) || (state_q == REL_DB);
  assign dbg_state_o = state_q;

endmodule
